// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine (MULT, MULTU, DIV, DIVU) with a
// start/busy/done handshake and an annul input for squashing in-flight work.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               accept_s;
  logic               sgn_s;
  logic               b_zero_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s, prod_fix_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH-1:0]   div_diff_s, rem_next_s, q_next_s, q_fix_s, r_fix_s;
  logic               div_ge_s;

  assign accept_s = start & ~annul & (state_q != CALC);
  assign sgn_s    = ~op[0];
  assign b_zero_s = (b == {WIDTH{1'b0}});
  assign abs_a_s  = (sgn_s & a[WIDTH-1]) ? -a : a;
  assign abs_b_s  = (sgn_s & b[WIDTH-1]) ? -b : b;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
  assign prod_fix_s = qneg_q ? -mul_next_s : mul_next_s;

  // Divide: restoring step; the difference fits WIDTH bits whenever it is kept.
  assign div_shift_s = {rem_q, acc_q[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, mb_q});
  assign div_diff_s  = div_shift_s[WIDTH-1:0] - mb_q;
  assign rem_next_s  = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
  assign q_next_s    = {acc_q[WIDTH-2:0], div_ge_s};
  assign q_fix_s     = qneg_q ? -q_next_s : q_next_s;
  assign r_fix_s     = rneg_q ? -rem_next_s : rem_next_s;

  // Next-state, datapath step and result write-back.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    zero_d   = zero_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    mb_d     = mb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d  = CALC;
          cnt_d    = CNT_W'(WIDTH);
          is_div_d = op[1];
          zero_d   = op[1] & b_zero_s;
          rem_d    = {WIDTH{1'b0}};
          dbz_d    = 1'b0;
          // A zero divisor runs on the raw dividend so the remainder comes out as a.
          if (op[1] & b_zero_s) begin
            acc_d  = {{WIDTH{1'b0}}, a};
            mb_d   = b;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, abs_a_s};
            mb_d   = abs_b_s;
            qneg_d = sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = sgn_s & op[1] & a[WIDTH-1];
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (is_div_q) begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], q_next_s};
            rem_d = rem_next_s;
          end else begin
            acc_d = mul_next_s;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            dbz_d   = zero_q;
            if (is_div_q) begin
              hi_d = r_fix_s;
              lo_d = q_fix_s;
            end else begin
              hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
              lo_d = prod_fix_s[WIDTH-1:0];
            end
          end else begin
            state_d = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      zero_q   <= 1'b0;
      acc_q    <= {(2*WIDTH){1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      mb_q     <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      mb_q     <= mb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC) | accept_s;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance for the full scenario set
// and an 8-bit instance for the narrow-width latency and sign cases.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, annul;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, dbz;
  logic        start8, annul8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dbz8;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .annul(annul), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .annul(annul8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
  );

  // Drives one operation from the current cycle and waits for done; returns
  // the start-to-done cycle count and whether busy followed the handshake.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int pulse_at, output int cyc, output bit busy_ok);
    op = o; a = av; b = bv; start = 1'b1; annul = 1'b0;
    #1;
    busy_ok = (busy === 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == pulse_at) begin
        start = 1'b1; a = 32'h0000_1234; b = 32'h0000_0005;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic run_op8(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                         output int cyc, output bit busy_ok);
    op8 = o; a8 = av; b8 = bv; start8 = 1'b1; annul8 = 1'b0;
    #1;
    busy_ok = (busy8 === 1'b1);
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 100) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (busy8 !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; annul = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    start8 = 1'b0; annul8 = 1'b0; op8 = 2'b00; a8 = 8'h0; b8 = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({hi, lo, done, busy, dbz} !== 67'h0)
      $display("FAIL reset32: got hi=%h lo=%h done=%b busy=%b dbz=%b, expected all zero", hi, lo, done, busy, dbz);
    else n_pass++;
    n_checks++;
    if ({hi8, lo8, done8, busy8, dbz8} !== 19'h0)
      $display("FAIL reset8: got hi=%h lo=%h done=%b busy=%b dbz=%b, expected all zero", hi8, lo8, done8, busy8, dbz8);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int cyc; bit bok;
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0, cyc, bok);
    n_checks++;
    if (cyc != 33) $display("FAIL mult_latency: got %0d expected 33", cyc); else n_pass++;
    n_checks++;
    if (!bok) $display("FAIL mult_busy: busy profile wrong, got 0 expected 1"); else n_pass++;
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL mult_neg: got %h_%h expected FFFFFFFF_FFFFFFEB", hi, lo);
    else n_pass++;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, bok);
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL multu_max: got %h_%h expected FFFFFFFE_00000001", hi, lo);
    else n_pass++;
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, cyc, bok);
    n_checks++;
    if ({hi, lo, dbz} !== {64'h4000_0000_0000_0000, 1'b0})
      $display("FAIL mult_minneg: got %h_%h dbz=%b expected 40000000_00000000 dbz=0", hi, lo, dbz);
    else n_pass++;
  endtask

  task automatic test_div();
    int cyc; bit bok;
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, cyc, bok);
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD)
      $display("FAIL div_neg_dividend: got hi=%h lo=%h expected hi=FFFFFFFF lo=FFFFFFFD", hi, lo);
    else n_pass++;
    n_checks++;
    if (cyc != 33) $display("FAIL div_latency: got %0d expected 33", cyc); else n_pass++;
    run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 0, cyc, bok);
    n_checks++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003)
      $display("FAIL divu_basic: got hi=%h lo=%h expected hi=1 lo=3", hi, lo);
    else n_pass++;
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 0, cyc, bok);
    n_checks++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD)
      $display("FAIL div_neg_divisor: got hi=%h lo=%h expected hi=1 lo=FFFFFFFD", hi, lo);
    else n_pass++;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, bok);
    n_checks++;
    if ({hi, lo, dbz} !== {64'h0000_0000_8000_0000, 1'b0})
      $display("FAIL div_overflow: got hi=%h lo=%h dbz=%b expected hi=0 lo=80000000 dbz=0", hi, lo, dbz);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    int cyc; bit bok;
    run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 0, cyc, bok);
    n_checks++;
    if ({hi, lo, dbz} !== {64'h0000_0005_FFFF_FFFF, 1'b1} || cyc != 33)
      $display("FAIL divu_zero: got hi=%h lo=%h dbz=%b cyc=%0d expected hi=5 lo=FFFFFFFF dbz=1 cyc=33", hi, lo, dbz, cyc);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (dbz !== 1'b1) $display("FAIL dbz_hold: got %b expected 1", dbz); else n_pass++;
    run_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 0, cyc, bok);
    n_checks++;
    if ({hi, lo, dbz} !== {64'hFFFF_FFFB_FFFF_FFFF, 1'b1})
      $display("FAIL div_zero_signed: got hi=%h lo=%h dbz=%b expected hi=FFFFFFFB lo=FFFFFFFF dbz=1", hi, lo, dbz);
    else n_pass++;
    op = 2'b11; a = 32'h0000_0009; b = 32'h0000_0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (dbz !== 1'b0) $display("FAIL dbz_clear: got %b expected 0", dbz); else n_pass++;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_0003)
      $display("FAIL divu_after_zero: got hi=%h lo=%h expected hi=0 lo=3", hi, lo);
    else n_pass++;
  endtask

  task automatic test_annul();
    bit seen = 1'b0;
    @(posedge clk); #1;
    op = 2'b00; a = 32'h3; b = 32'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL annul_idle: busy got %b expected 0", busy); else n_pass++;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL annul_no_done: done got 1 expected 0"); else n_pass++;
    n_checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_0003)
      $display("FAIL annul_hold: got hi=%h lo=%h expected hi=0 lo=3", hi, lo);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int cyc; bit bok;
    run_op(2'b11, 32'd100, 32'd7, 5, cyc, bok);
    n_checks++;
    if (cyc != 33 || {hi, lo} !== 64'h0000_0002_0000_000E)
      $display("FAIL start_mid_calc: got cyc=%0d hi=%h lo=%h expected cyc=33 hi=2 lo=E", cyc, hi, lo);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b00)
      $display("FAIL start_mid_calc_idle: got busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc; bit bok;
    run_op(2'b01, 32'd6, 32'd7, 0, cyc, bok);
    n_checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_002A)
      $display("FAIL b2b_first: got hi=%h lo=%h expected hi=0 lo=2A", hi, lo);
    else n_pass++;
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0, cyc, bok);
    n_checks++;
    if (cyc != 33 || !bok)
      $display("FAIL b2b_latency: got cyc=%0d busy_ok=%b expected cyc=33 busy_ok=1", cyc, bok);
    else n_pass++;
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_FFFF_FFF2)
      $display("FAIL b2b_second: got hi=%h lo=%h expected hi=FFFFFFFE lo=FFFFFFF2", hi, lo);
    else n_pass++;
  endtask

  task automatic test_start_annul();
    bit seen = 1'b0;
    op = 2'b11; a = 32'd1; b = 32'd1; start = 1'b1; annul = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL start_annul_busy: got %b expected 0", busy); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    repeat (5) begin
      if (busy === 1'b1 || done === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen || {hi, lo} !== 64'hFFFF_FFFE_FFFF_FFF2)
      $display("FAIL start_annul_idle: got activity=%b hi=%h lo=%h expected 0 FFFFFFFE FFFFFFF2", seen, hi, lo);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    op = 2'b00; a = 32'h3; b = 32'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({hi, lo, done, busy} !== 66'h0)
      $display("FAIL async_reset: got hi=%h lo=%h done=%b busy=%b expected all zero", hi, lo, done, busy);
    else n_pass++;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b00)
      $display("FAIL async_reset_idle: got busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_width8();
    int cyc; bit bok;
    run_op8(2'b00, 8'hFD, 8'h07, cyc, bok);
    n_checks++;
    if (cyc != 9 || !bok || {hi8, lo8} !== 16'hFFEB)
      $display("FAIL w8_mult: got cyc=%0d busy_ok=%b hi=%h lo=%h expected 9 1 FF EB", cyc, bok, hi8, lo8);
    else n_pass++;
    run_op8(2'b10, 8'hF9, 8'h02, cyc, bok);
    n_checks++;
    if (cyc != 9 || !bok || {hi8, lo8} !== 16'hFFFD)
      $display("FAIL w8_div: got cyc=%0d busy_ok=%b hi=%h lo=%h expected 9 1 FF FD", cyc, bok, hi8, lo8);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_annul();
    test_start_ignored();
    test_back_to_back();
    test_start_annul();
    test_async_reset();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
